// File: rtl/nibbler_pkg.sv
// Shared types for the nibbler core: opcode encoding and sequencer states.
package nibbler_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LIT  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_CMP  = 4'h7,
        OP_IN   = 4'h8,
        OP_OUT  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JC   = 4'hB,
        OP_JZ   = 4'hC,
        OP_JNZ  = 4'hD,
        OP_CALL = 4'hE,
        OP_RET  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        IN_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/nibbler_core_p_call_stack.sv
// Return-address LIFO; pushes when full and pops when empty are ignored.
module call_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  din,
    output logic [ADDR_W-1:0]                  dout,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [2**IDX_W];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  wr_idx, top_idx;

    assign full    = (count_q == CNT_W'(STACK_DEPTH));
    assign empty   = (count_q == '0);
    assign wr_idx  = count_q[IDX_W-1:0];
    assign top_idx = IDX_W'(count_q - CNT_W'(1));
    assign dout    = mem_q[top_idx];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry contents need no reset; only the occupancy count matters.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/nibbler_core_p.sv
// Fetch/execute accumulator core with call stack and ready/valid input port.
// Jump targets narrower than ADDR_W are zero-extended from the second word.
module nibbler_core_p
    import nibbler_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4,
    parameter int INSTR_W     = DATA_W + 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [INSTR_W-1:0]               prog_data,
    output logic [ADDR_W-1:0]                prog_addr,
    input  logic [DATA_W-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_strobe,
    output logic [ADDR_W-1:0]                pc,
    output logic                             phase,
    output logic [DATA_W-1:0]                accu,
    output logic                             c_flag,
    output logic                             z_flag,
    output logic                             stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp
);
    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   accu_q, accu_d, out_data_q, out_data_d;
    logic                c_q, c_d, z_q, z_d;
    logic                out_strobe_q, out_strobe_d, stack_err_q, stack_err_d;

    opcode_t             opc;
    logic [DATA_W-1:0]   op, diff;
    logic [DATA_W:0]     sum;
    logic                no_borrow;
    logic [ADDR_W-1:0]   target, pc_inc, st_dout;
    logic                push, pop, st_full, st_empty;

    assign opc       = opcode_t'(instr_q[INSTR_W-1 -: OPC_W]);
    assign op        = instr_q[DATA_W-1:0];
    assign sum       = {1'b0, accu_q} + {1'b0, op};
    assign diff      = accu_q - op;
    assign no_borrow = (accu_q >= op);
    assign pc_inc    = pc_q + ADDR_W'(1);

    generate
        if (ADDR_W <= INSTR_W) begin : g_tgt_slice
            assign target = prog_data[ADDR_W-1:0];
        end else begin : g_tgt_ext
            assign target = {{(ADDR_W-INSTR_W){1'b0}}, prog_data};
        end
    endgenerate

    // Ready is combinational so IN can complete in its own EXEC cycle.
    assign in_ready = !reset &&
                      ((state_q == IN_WAIT) || (state_q == EXEC && opc == OP_IN));

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        accu_d       = accu_q;
        c_d          = c_q;
        z_d          = z_q;
        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;
        stack_err_d  = stack_err_q;
        push         = 1'b0;
        pop          = 1'b0;
        case (state_q)
            FETCH: begin
                instr_d = prog_data;
                pc_d    = pc_inc;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                case (opc)
                    OP_NOP: ;
                    OP_LIT: begin accu_d = op; z_d = (op == '0); end
                    OP_ADD: begin
                        {c_d, accu_d} = sum;
                        z_d = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin accu_d = diff; c_d = no_borrow; z_d = (diff == '0); end
                    OP_AND: begin accu_d = accu_q & op; c_d = 1'b0; z_d = ((accu_q & op) == '0); end
                    OP_OR:  begin accu_d = accu_q | op; c_d = 1'b0; z_d = ((accu_q | op) == '0); end
                    OP_XOR: begin accu_d = accu_q ^ op; c_d = 1'b0; z_d = ((accu_q ^ op) == '0); end
                    OP_CMP: begin c_d = no_borrow; z_d = (diff == '0); end
                    OP_IN: begin
                        if (in_valid) begin
                            accu_d = in_data;
                            z_d    = (in_data == '0);
                        end else begin
                            state_d = IN_WAIT;
                        end
                    end
                    OP_OUT: begin out_data_d = accu_q; out_strobe_d = 1'b1; end
                    OP_JMP: pc_d = target;
                    OP_JC:  pc_d = c_q  ? target : pc_inc;
                    OP_JZ:  pc_d = z_q  ? target : pc_inc;
                    OP_JNZ: pc_d = !z_q ? target : pc_inc;
                    OP_CALL: begin
                        if (!st_full) begin
                            push = 1'b1;
                            pc_d = target;
                        end else begin
                            pc_d        = pc_inc;
                            stack_err_d = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (!st_empty) begin
                            pop  = 1'b1;
                            pc_d = st_dout;
                        end else begin
                            stack_err_d = 1'b1;
                        end
                    end
                endcase
            end
            IN_WAIT: begin
                if (in_valid) begin
                    accu_d  = in_data;
                    z_d     = (in_data == '0);
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            instr_q      <= '0;
            pc_q         <= '0;
            accu_q       <= '0;
            c_q          <= 1'b0;
            z_q          <= 1'b0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            stack_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            accu_q       <= accu_d;
            c_q          <= c_d;
            z_q          <= z_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            stack_err_q  <= stack_err_d;
        end
    end

    call_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (st_dout),
        .full  (st_full),
        .empty (st_empty),
        .count (sp)
    );

    assign prog_addr  = pc_q;
    assign pc         = pc_q;
    assign phase      = (state_q != FETCH);
    assign accu       = accu_q;
    assign c_flag     = c_q;
    assign z_flag     = z_q;
    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign stack_err  = stack_err_q;

endmodule

// File: tb/tb_nibbler_core_p.sv
// Directed program run against a bench-side ROM; OUT values checked via a scoreboard queue.
module tb_nibbler_core_p;
    localparam int DATA_W      = 4;
    localparam int ADDR_W      = 12;
    localparam int STACK_DEPTH = 2;
    localparam int INSTR_W     = DATA_W + 4;
    localparam int SP_W        = $clog2(STACK_DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [INSTR_W-1:0] prog_data;
    logic [ADDR_W-1:0]  prog_addr;
    logic [DATA_W-1:0]  in_data = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_strobe;
    logic [ADDR_W-1:0]  pc;
    logic               phase;
    logic [DATA_W-1:0]  accu;
    logic               c_flag, z_flag, stack_err;
    logic [SP_W-1:0]    sp;

    logic [INSTR_W-1:0] rom [2**ADDR_W];
    logic [DATA_W-1:0]  exp_q [$];
    int checks = 0;
    int failures = 0;

    assign prog_data = rom[prog_addr];

    always #5 clk = ~clk;

    nibbler_core_p #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_data  (prog_data),
        .prog_addr  (prog_addr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_strobe (out_strobe),
        .pc         (pc),
        .phase      (phase),
        .accu       (accu),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .stack_err  (stack_err),
        .sp         (sp)
    );

    function automatic logic [7:0] enc(input logic [3:0] o, input logic [3:0] v);
        return {o, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample; every OUT pulse is matched against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (out_strobe === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL strobe_unexpected observed=1 expected=0");
            end
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
        end
    endtask

    task automatic exec_one();
        tick();
        tick();
    endtask

    task automatic run_to(input logic [ADDR_W-1:0] addr, input int maxc);
        int n = 0;
        while (!(phase === 1'b0 && pc === addr) && n < maxc) begin
            tick();
            n++;
        end
        chk("run_to_pc", pc, addr);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},         pc, 0);
        chk({tag, "_accu"},       accu, 0);
        chk({tag, "_flags"},      {c_flag, z_flag}, 0);
        chk({tag, "_out_data"},   out_data, 0);
        chk({tag, "_out_strobe"}, out_strobe, 0);
        chk({tag, "_in_ready"},   in_ready, 0);
        chk({tag, "_stack_err"},  stack_err, 0);
        chk({tag, "_sp"},         sp, 0);
        chk({tag, "_phase"},      phase, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = '0;
        rom[12'h000] = enc(4'h1, 4'h9);   // LIT 9
        rom[12'h001] = enc(4'h2, 4'h8);   // ADD 8
        rom[12'h002] = enc(4'h3, 4'h1);   // SUB 1
        rom[12'h003] = enc(4'h1, 4'h3);   // LIT 3
        rom[12'h004] = enc(4'h7, 4'h5);   // CMP 5
        rom[12'h005] = enc(4'hB, 4'h0);   // JC 0x20
        rom[12'h006] = 8'h20;
        rom[12'h007] = enc(4'hD, 4'h0);   // JNZ 0x20
        rom[12'h008] = 8'h20;
        rom[12'h009] = enc(4'h8, 4'h0);   // IN (reached only from the top-address jump)
        rom[12'h020] = enc(4'h2, 4'hF);   // ADD F
        rom[12'h021] = enc(4'h6, 4'h2);   // XOR 2
        rom[12'h022] = enc(4'hC, 4'h0);   // JZ 0x30
        rom[12'h023] = 8'h30;
        rom[12'h030] = enc(4'h1, 4'hC);   // LIT C
        rom[12'h031] = enc(4'h4, 4'h6);   // AND 6
        rom[12'h032] = enc(4'h5, 4'h1);   // OR 1
        rom[12'h033] = enc(4'h8, 4'h0);   // IN
        rom[12'h034] = enc(4'h9, 4'h0);   // OUT
        rom[12'h035] = enc(4'h8, 4'h0);   // IN
        rom[12'h036] = enc(4'h9, 4'h0);   // OUT
        rom[12'h037] = enc(4'hA, 4'h0);   // JMP 0x40
        rom[12'h038] = 8'h40;
        rom[12'h040] = enc(4'hE, 4'h0);   // CALL 0x50
        rom[12'h041] = 8'h50;
        rom[12'h042] = enc(4'hF, 4'h0);   // RET on empty stack
        rom[12'h050] = enc(4'hE, 4'h0);   // CALL 0x60
        rom[12'h051] = 8'h60;
        rom[12'h052] = enc(4'hF, 4'h0);   // RET
        rom[12'h060] = enc(4'hE, 4'h0);   // CALL 0x70 (stack full)
        rom[12'h061] = 8'h70;
        rom[12'h062] = enc(4'hF, 4'h0);   // RET
        rom[12'hFFE] = enc(4'hA, 4'h0);   // JMP 0x009 with target at top address
        rom[12'hFFF] = 8'h09;

        tick(); tick(); tick();
        chk_reset_state("reset");
        reset = 1'b0;

        run_to(12'h002, 20);
        chk("add_accu", accu, 4'h1);
        chk("add_cz", {c_flag, z_flag}, 2'b10);
        run_to(12'h003, 20);
        chk("sub_accu", accu, 4'h0);
        chk("sub_cz", {c_flag, z_flag}, 2'b11);
        run_to(12'h005, 20);
        chk("cmp_accu", accu, 4'h3);
        chk("cmp_cz", {c_flag, z_flag}, 2'b00);
        exec_one();
        chk("jc_not_taken_pc", pc, 12'h007);
        exec_one();
        chk("jnz_taken_pc", pc, 12'h020);
        exec_one();
        chk("add_wrap_accu", accu, 4'h2);
        chk("add_wrap_cz", {c_flag, z_flag}, 2'b10);
        exec_one();
        chk("xor_accu", accu, 4'h0);
        chk("xor_cz", {c_flag, z_flag}, 2'b01);
        exec_one();
        chk("jz_taken_pc", pc, 12'h030);
        exec_one();
        exec_one();
        chk("and_accu", accu, 4'h4);
        chk("and_cz", {c_flag, z_flag}, 2'b00);
        exec_one();
        chk("or_accu", accu, 4'h5);

        // IN with three idle cycles before data arrives
        tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready === 1'b1) cnt++;
            if (i == 3) begin
                in_valid = 1'b1;
                in_data  = 4'hA;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("in_ready_cycles", cnt, 4);
        chk("in_accu", accu, 4'hA);
        chk("in_done_ready", in_ready, 0);
        chk("in_done_pc", pc, 12'h034);

        exp_q.push_back(4'hA);
        exec_one();
        chk("out_reg", out_data, 4'hA);
        tick();
        chk("out_strobe_len", out_strobe, 0);
        chk("in_exec_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 4'h5;
        tick();
        in_valid = 1'b0;
        chk("in_fast_accu", accu, 4'h5);
        chk("in_fast_pc", pc, 12'h036);
        exp_q.push_back(4'h5);
        exec_one();
        exec_one();
        chk("jmp_pc", pc, 12'h040);

        exec_one();
        chk("call1_pc", pc, 12'h050);
        chk("call1_sp", sp, 1);
        exec_one();
        chk("call2_sp", sp, 2);
        chk("call2_err", stack_err, 0);
        exec_one();
        chk("call3_pc", pc, 12'h062);
        chk("call3_sp", sp, 2);
        chk("call3_err", stack_err, 1);
        exec_one();
        chk("ret1_pc", pc, 12'h052);
        chk("ret1_sp", sp, 1);
        exec_one();
        chk("ret2_pc", pc, 12'h042);
        chk("ret2_sp", sp, 0);
        exec_one();
        chk("ret3_pc", pc, 12'h043);
        chk("ret3_sp", sp, 0);
        chk("ret3_err", stack_err, 1);

        run_to(12'hFFE, 12000);
        exec_one();
        chk("top_jmp_pc", pc, 12'h009);

        // Reset while parked in IN_WAIT
        tick(); tick(); tick();
        chk("wait_ready", in_ready, 1);
        chk("wait_phase", phase, 1);
        reset = 1'b1;
        #1;
        chk("reset_ready_drop", in_ready, 0);
        tick();
        chk_reset_state("mid_reset");

        // NOP at the top address must wrap the fetch counter
        rom[12'hFFE] = '0;
        rom[12'hFFF] = '0;
        in_valid = 1'b1;
        in_data  = 4'h0;
        exp_q.push_back(4'h0);
        exp_q.push_back(4'h0);
        tick();
        reset = 1'b0;
        run_to(12'hFFF, 12000);
        exec_one();
        chk("wrap_pc", pc, 12'h000);
        chk("wrap_phase", phase, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
